// File: rtl/multiplier_2bit_sequencer.sv
// Sequential WIDTH x WIDTH unsigned multiplier built around one shared external 2x2-bit multiplier.
// Optional macro ZERO_EARLY_EXIT_EN: a zero operand skips the digit loop and finishes in one cycle.
module multiplier_2bit_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in_1,
  input  logic [WIDTH-1:0]     in_2,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   out,
  output logic [1:0]           mul_a,
  output logic [1:0]           mul_b,
  input  logic [3:0]           mul_p
);

  localparam int N  = WIDTH / 2;
  localparam int NN = N * N;
  localparam int KW = (NN > 1) ? $clog2(NN) : 1;
  localparam int PW = 2 * WIDTH;
  localparam logic [KW-1:0] K_ZERO = KW'(0);
  localparam logic [KW-1:0] K_ONE  = KW'(1);
  localparam logic [KW-1:0] K_LAST = KW'(NN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   out_q, out_d;
  logic [KW-1:0]   k_q, k_d;

  int              idx_i_s;
  int              idx_j_s;
  logic [1:0]      dig_a_s;
  logic [1:0]      dig_b_s;
  logic [PW-1:0]   pp_shift_s;
  logic [PW-1:0]   acc_sum_s;

  // Digit selection for step k: i walks the multiplicand fastest, j the multiplier.
  always_comb begin
    idx_i_s    = int'(k_q) % N;
    idx_j_s    = int'(k_q) / N;
    dig_a_s    = a_q[2*idx_i_s +: 2];
    dig_b_s    = b_q[2*idx_j_s +: 2];
    pp_shift_s = PW'(mul_p) << (2 * (idx_i_s + idx_j_s));
    acc_sum_s  = acc_q + pp_shift_s;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    out_d   = out_q;
    k_d     = k_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d   = in_1;
          b_d   = in_2;
          acc_d = {PW{1'b0}};
          k_d   = K_ZERO;
`ifdef ZERO_EARLY_EXIT_EN
          if ((in_1 == {WIDTH{1'b0}}) || (in_2 == {WIDTH{1'b0}})) begin
            out_d   = {PW{1'b0}};
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
`else
          state_d = ST_RUN;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d = acc_sum_s;
        if (k_q == K_LAST) begin
          // The final partial product goes straight into out, no extra cycle.
          out_d   = acc_sum_s;
          k_d     = K_ZERO;
          state_d = ST_DONE;
        end else begin
          k_d     = k_q + K_ONE;
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any multiplication in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      acc_q   <= {PW{1'b0}};
      out_q   <= {PW{1'b0}};
      k_q     <= K_ZERO;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      k_q     <= k_d;
    end
  end

  // Outputs decode registered state only; digits are driven solely while running.
  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
    out  = out_q;
    if (state_q == ST_RUN) begin
      mul_a = dig_a_s;
      mul_b = dig_b_s;
    end else begin
      mul_a = 2'b00;
      mul_b = 2'b00;
    end
  end

endmodule

// File: tb/tb_multiplier_2bit_sequencer.sv
// Directed self-checking bench for multiplier_2bit_sequencer (WIDTH=8 and WIDTH=2 instances).
module tb_multiplier_2bit_sequencer;

  logic        clk;
  logic        rst_n;

  logic        start8;
  logic [7:0]  in_1_8, in_2_8;
  logic        busy8, done8;
  logic [15:0] out8;
  logic [1:0]  mul_a8, mul_b8;
  logic [3:0]  mul_p8;

  logic        start2;
  logic [1:0]  in_1_2, in_2_2;
  logic        busy2, done2;
  logic [3:0]  out2;
  logic [1:0]  mul_a2, mul_b2;
  logic [3:0]  mul_p2;

  int          n_checks;
  int          n_pass;
  logic [1:0]  first_ma, first_mb;
  logic        first_busy;
  int          lat;
  logic        mid_drop;
  int          hold_err;

  multiplier_2bit_sequencer #(.WIDTH(8)) u_dut_w8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .in_1(in_1_8), .in_2(in_2_8),
    .busy(busy8), .done(done8), .out(out8), .mul_a(mul_a8), .mul_b(mul_b8), .mul_p(mul_p8)
  );

  multiplier_2bit_sequencer #(.WIDTH(2)) u_dut_w2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .in_1(in_1_2), .in_2(in_2_2),
    .busy(busy2), .done(done2), .out(out2), .mul_a(mul_a2), .mul_b(mul_b2), .mul_p(mul_p2)
  );

  // External 2x2 digit multipliers
  assign mul_p8 = {2'b00, mul_a8} * {2'b00, mul_b8};
  assign mul_p2 = {2'b00, mul_a2} * {2'b00, mul_b2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Starts one WIDTH=8 multiplication and waits (bounded) for done.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input int restart_at);
    in_1_8 = a;
    in_2_8 = b;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8     = 1'b0;
    first_ma   = mul_a8;
    first_mb   = mul_b8;
    first_busy = busy8;
    lat        = 0;
    mid_drop   = 1'b0;
    while (!done8 && lat < 40) begin
      if (!busy8) mid_drop = 1'b1;
      if (lat == restart_at) begin
        in_1_8 = 8'd2;
        in_2_8 = 8'd2;
        start8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start8 = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    start8   = 1'b0;
    in_1_8   = 8'd0;
    in_2_8   = 8'd0;
    start2   = 1'b0;
    in_1_2   = 2'd0;
    in_2_2   = 2'd0;

    #12;
    check("rst_busy8",  32'(busy8),  32'd0);
    check("rst_done8",  32'(done8),  32'd0);
    check("rst_out8",   32'(out8),   32'd0);
    check("rst_mul_a8", 32'(mul_a8), 32'd0);
    check("rst_mul_b8", 32'(mul_b8), 32'd0);
    check("rst_out2",   32'(out2),   32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 13 * 11
    run8(8'd13, 8'd11, -1);
    check("t1_first_busy", 32'(first_busy), 32'd1);
    check("t1_mul_a_k0",   32'(first_ma),   32'd1);
    check("t1_mul_b_k0",   32'(first_mb),   32'd3);
    check("t1_latency",    32'(lat),        32'd16);
    check("t1_done",       32'(done8),      32'd1);
    check("t1_out",        32'(out8),       32'd143);
    check("t1_no_drop",    32'(mid_drop),   32'd0);
    check("t1_done_mul_a", 32'(mul_a8),     32'd0);
    @(posedge clk); #1;
    check("t1_done_pulse", 32'(done8),      32'd0);
    check("t1_idle_busy",  32'(busy8),      32'd0);

    // 255 * 255, then out holds through idle
    run8(8'hFF, 8'hFF, -1);
    check("t2_latency", 32'(lat),   32'd16);
    check("t2_out",     32'(out8),  32'hFE01);
    @(posedge clk); #1;
    check("t2_done_pulse", 32'(done8), 32'd0);
    hold_err = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (out8 !== 16'hFE01 || busy8 !== 1'b0) hold_err++;
    end
    check("t2_hold", 32'(hold_err), 32'd0);

    // 37 * 201 with start and operand change at RUN cycle 5
    run8(8'd37, 8'd201, 5);
    check("t3_latency", 32'(lat),      32'd16);
    check("t3_out",     32'(out8),     32'h1D0D);
    check("t3_no_drop", 32'(mid_drop), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t3_not_queued", 32'(busy8), 32'd0);

    // Reset abort in the middle of 200 * 100
    in_1_8 = 8'd200;
    in_2_8 = 8'd100;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
    end
    check("t4_busy_before", 32'(busy8), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t4_abort_busy", 32'(busy8), 32'd0);
    check("t4_abort_done", 32'(done8), 32'd0);
    check("t4_abort_out",  32'(out8),  32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run8(8'd7, 8'd9, -1);
    check("t4_latency", 32'(lat),  32'd16);
    check("t4_out",     32'(out8), 32'd63);
    @(posedge clk); #1;

    // Zero operand
    run8(8'd0, 8'd55, -1);
`ifdef ZERO_EARLY_EXIT_EN
    check("t5_latency", 32'(lat), 32'd0);
`else
    check("t5_latency", 32'(lat), 32'd16);
`endif
    check("t5_done",  32'(done8), 32'd1);
    check("t5_out",   32'(out8),  32'd0);
    @(posedge clk); #1;

    // WIDTH=2: 3 * 3 then back-to-back 2 * 3
    in_1_2 = 2'd3;
    in_2_2 = 2'd3;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    check("w2_run_busy",  32'(busy2),  32'd1);
    check("w2_run_done",  32'(done2),  32'd0);
    check("w2_run_mul_a", 32'(mul_a2), 32'd3);
    check("w2_run_mul_b", 32'(mul_b2), 32'd3);
    @(posedge clk); #1;
    check("w2_done",       32'(done2),  32'd1);
    check("w2_out",        32'(out2),   32'd9);
    check("w2_done_mul_a", 32'(mul_a2), 32'd0);
    @(posedge clk); #1;
    check("w2_idle_busy", 32'(busy2), 32'd0);
    in_1_2 = 2'd2;
    in_2_2 = 2'd3;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    check("w2_b2b_busy", 32'(busy2), 32'd1);
    @(posedge clk); #1;
    check("w2_b2b_done", 32'(done2), 32'd1);
    check("w2_b2b_out",  32'(out2),  32'd6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
